hamming74_tx_serial: RTL and testbench

Transmit end of the Hamming(7,4) link. It accepts a 4-bit data nibble through a valid/ready handshake and encodes it into a 7-bit codeword. If requested, it flips one codeword bit so that the receiver's 3-bit syndrome equals that bit position. It then serialises the codeword as a start/7-data/stop frame. The receiver decodes the frame, and its syndrome drives the 7-segment syndrome display.

---
 rtl/hamming_pkg.sv | 21 ++
 rtl/hamming74_tx_serial_encoder.sv | 12 +
 rtl/hamming74_tx_serial.sv | 112 +++++++++++
 tb/tb_hamming74_tx_serial.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) types and encoder function for the serial link.
package hamming_pkg;

  localparam int unsigned CODE_W = 7;
  localparam int unsigned DATA_W = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Positions 1..7 are p1 p2 d1 p4 d2 d3 d4; err_pos selects a position to invert.
  function automatic logic [CODE_W-1:0] hamming74_encode(input logic [DATA_W-1:0] data,
                                                         input logic [2:0]        err_pos);
    logic              p1, p2, p4;
    logic [CODE_W-1:0] mask;
    p1   = data[0] ^ data[1] ^ data[3];
    p2   = data[0] ^ data[2] ^ data[3];
    p4   = data[1] ^ data[2] ^ data[3];
    mask = (err_pos == 3'd0) ? '0 : CODE_W'(7'd1 << (err_pos - 3'd1));
    return {data[3], data[2], data[1], p4, data[0], p2, p1} ^ mask;
  endfunction

endpackage

// File: rtl/hamming74_tx_serial_encoder.sv
// Combinational Hamming(7,4) parity generation with optional single-bit injection.
module hamming74_encoder
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [2:0]        err_pos,
  output logic [CODE_W-1:0] code
);

  assign code = hamming74_encode(data, err_pos);

endmodule

// File: rtl/hamming74_tx_serial.sv
// Hamming(7,4) transmitter: accepts a nibble, encodes it, sends start/7-data/stop frame.
module hamming74_tx_serial
  import hamming_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] data_in,
  input  logic [2:0] err_pos,
  output logic [6:0] code_out,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  localparam int unsigned     CW       = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t         state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [2:0]        bit_idx, bit_n;
  logic [CODE_W-1:0] shreg, shreg_n, code_n, enc;
  logic              last_cyc;

  hamming74_encoder u_enc (
    .data    (data_in),
    .err_pos (err_pos),
    .code    (enc)
  );

  assign last_cyc = (cnt == CNT_LAST);
  assign busy     = (state != IDLE);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_idx;
    shreg_n  = shreg;
    code_n   = code_out;
    tx_out   = 1'b1;
    done     = 1'b0;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) begin
          state_n = START;
          cnt_n   = '0;
          bit_n   = '0;
          shreg_n = enc;
          code_n  = enc;
        end
      end
      START: begin
        tx_out = 1'b0;
        if (last_cyc) begin
          state_n = DATA;
          cnt_n   = '0;
          bit_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        tx_out = shreg[0];
        if (last_cyc) begin
          cnt_n   = '0;
          shreg_n = {1'b0, shreg[CODE_W-1:1]};
          if (bit_idx == 3'd6) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        // A reset landing on the final stop cycle must not leak a done pulse.
        done = last_cyc && !rst;
        if (last_cyc) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        bit_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      code_out <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      shreg    <= shreg_n;
      code_out <= code_n;
    end
  end

endmodule

// File: tb/tb_hamming74_tx_serial.sv
// Directed bench for hamming74_tx_serial at four clocks per serial bit.
module tb_hamming74_tx_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] data_in;
  logic [2:0] err_pos;
  logic [6:0] code_out;
  logic       tx_out;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  hamming74_tx_serial #(.CLKS_PER_BIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .err_pos  (err_pos),
    .code_out (code_out),
    .tx_out   (tx_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Generator rows per data bit: d1->0x07, d2->0x19, d3->0x2A, d4->0x4B.
  function automatic logic [6:0] ref_code(input logic [3:0] d, input logic [2:0] e);
    logic [6:0] c;
    c = 7'h00;
    if (d[0]) c ^= 7'h07;
    if (d[1]) c ^= 7'h19;
    if (d[2]) c ^= 7'h2A;
    if (d[3]) c ^= 7'h4B;
    if (e != 3'd0) c[int'(e) - 1] = ~c[int'(e) - 1];
    return c;
  endfunction

  function automatic logic [2:0] syndrome(input logic [6:0] c);
    logic [2:0] s;
    s = 3'd0;
    for (int unsigned k = 0; k < 7; k++)
      if (c[k]) s ^= 3'(k + 1);
    return s;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // One full frame; returns the sampled frame bits (bit 0 = start, bit 8 = stop).
  task automatic run_frame(input logic [3:0] d, input logic [2:0] e, output logic [8:0] cap);
    logic [6:0] exp_code;
    logic [8:0] frame;
    int         ndone, done_at;
    logic       ok;
    exp_code = ref_code(d, e);
    frame    = {1'b1, exp_code, 1'b0};
    ndone    = 0;
    done_at  = 0;
    ok       = 1'b1;
    cap      = '0;
    wait_ready();
    data_in  = d;
    err_pos  = e;
    in_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (c == 1) begin
        in_valid = 1'b0;
        check("code", {25'd0, code_out}, {25'd0, exp_code});
      end
      if (tx_out !== frame[(c - 1) / 4]) ok = 1'b0;
      if (busy !== 1'b1 || code_out !== exp_code) ok = 1'b0;
      if ((c % 4) == 2) cap[(c - 1) / 4] = tx_out;
      if (done) begin
        ndone++;
        done_at = c;
      end
    end
    check("frame_ok", {31'd0, ok}, 32'd1);
    check("done_count", ndone, 32'd1);
    check("done_cycle", done_at, 32'd36);
    @(negedge clk);
    check("ready_after", {31'd0, in_ready}, 32'd1);
    check("busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [8:0] cap;
    int         done_at, ndone, n;
    logic       stable;

    rst = 1'b1; in_valid = 1'b0; data_in = '0; err_pos = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx", {31'd0, tx_out}, 32'd1);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_code", {25'd0, code_out}, 32'h00);

    run_frame(4'b1011, 3'd0, cap);
    check("code_55", {25'd0, code_out}, 32'h55);
    check("frame_55", {23'd0, cap}, 32'h1AA);

    run_frame(4'b1011, 3'd3, cap);
    check("code_51", {25'd0, code_out}, 32'h51);
    check("frame_51", {23'd0, cap}, 32'h1A2);
    check("syndrome_3", {29'd0, syndrome(cap[7:1])}, 32'd3);

    run_frame(4'h0, 3'd7, cap);
    check("code_40", {25'd0, code_out}, 32'h40);
    run_frame(4'hF, 3'd0, cap);
    check("code_7f", {25'd0, code_out}, 32'h7F);

    for (int unsigned d = 0; d < 16; d++)
      for (int unsigned e = 0; e < 8; e++) begin
        run_frame(4'(d), 3'(e), cap);
        check("sweep_syn", {29'd0, syndrome(cap[7:1])}, e);
      end

    // Back-to-back with in_valid held and inputs changing mid-frame.
    wait_ready();
    data_in = 4'hA; err_pos = 3'd0; in_valid = 1'b1;
    @(posedge clk);
    stable = 1'b1; done_at = 0;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (code_out !== ref_code(4'hA, 3'd0)) stable = 1'b0;
      if (done) done_at = c;
      if (c == 10) data_in = 4'h3;
      if (c == 20) err_pos = 3'd5;
    end
    check("b2b_stable", {31'd0, stable}, 32'd1);
    check("b2b_done", done_at, 32'd36);
    @(negedge clk);
    check("b2b_idle_ready", {31'd0, in_ready}, 32'd1);
    check("b2b_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("b2b_start_busy", {31'd0, busy}, 32'd1);
    check("b2b_start_tx", {31'd0, tx_out}, 32'd0);
    check("b2b_code2", {25'd0, code_out}, {25'd0, ref_code(4'h3, 3'd5)});
    in_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b_drain", {31'd0, busy}, 32'd0);

    // Reset during DATA bit 3 (cycles 17..20 of the frame).
    wait_ready();
    data_in = 4'b1011; err_pos = 3'd0; in_valid = 1'b1;
    @(posedge clk);
    ndone = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (done) ndone++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", {31'd0, tx_out}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_code", {25'd0, code_out}, 32'h00);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mid_rst_nodone", ndone, 32'd0);
    run_frame(4'h6, 3'd2, cap);
    check("post_rst_frame", {23'd0, cap}, {23'd0, 1'b1, ref_code(4'h6, 3'd2), 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
